// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU codes, write-back/immediate
// selectors, FSM states and the control bundle handed to execute.
package decode_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [2:0] {
        WB_ALU  = 3'd0,
        WB_MEM  = 3'd1,
        WB_PC4  = 3'd2,
        WB_IMM  = 3'd3,
        WB_NONE = 3'd4
    } wdata_sel_e;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    typedef struct packed {
        logic [3:0] alu_func;
        wdata_sel_e wdata_sel;
        imm_fmt_e   op2_immediate;
        logic       op1_pc;
        logic       op1_zero;
        logic       load_control;
        logic       store_control;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic [2:0] br_funct3;
    } ctrl_t;

    // alt selects SUB/SRA; callers only pass it where funct7 is meaningful
    function automatic logic [3:0] alu_from_funct3(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [3:0] r;
        unique case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational RV32I decode: opcode/funct fields to control bundle,
// operand usage, legality flag and sign-extended immediate.
module decode_ctrl
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [31:0] imm32;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        ctrl           = '0;
        ctrl.wdata_sel = WB_NONE;
        uses_rs1       = 1'b0;
        uses_rs2       = 1'b0;
        illegal        = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                illegal = !(f7 == F7_BASE ||
                            (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
                ctrl.alu_func  = alu_from_funct3(f3, f7 == F7_ALT);
                ctrl.wdata_sel = WB_ALU;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OPC_OP_IMM: begin
                if (f3 == 3'b001)
                    illegal = f7 != F7_BASE;
                else if (f3 == 3'b101)
                    illegal = !(f7 == F7_BASE || f7 == F7_ALT);
                ctrl.alu_func      = alu_from_funct3(f3, f3 == 3'b101 && instr[30]);
                ctrl.wdata_sel     = WB_ALU;
                ctrl.op2_immediate = FMT_I;
                uses_rs1           = 1'b1;
            end
            OPC_LOAD: begin
                illegal = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
                ctrl.wdata_sel     = WB_MEM;
                ctrl.op2_immediate = FMT_I;
                ctrl.load_control  = 1'b1;
                uses_rs1           = 1'b1;
            end
            OPC_STORE: begin
                illegal = !(f3 inside {3'b000, 3'b001, 3'b010});
                ctrl.op2_immediate = FMT_S;
                ctrl.store_control = 1'b1;
                uses_rs1           = 1'b1;
                uses_rs2           = 1'b1;
            end
            OPC_BRANCH: begin
                illegal = f3 == 3'b010 || f3 == 3'b011;
                ctrl.op2_immediate = FMT_B;
                ctrl.op1_pc        = 1'b1;
                ctrl.is_branch     = 1'b1;
                ctrl.br_funct3     = f3;
                uses_rs1           = 1'b1;
                uses_rs2           = 1'b1;
            end
            OPC_JAL: begin
                ctrl.wdata_sel     = WB_PC4;
                ctrl.op2_immediate = FMT_J;
                ctrl.op1_pc        = 1'b1;
                ctrl.is_jal        = 1'b1;
            end
            OPC_JALR: begin
                illegal = f3 != 3'b000;
                ctrl.wdata_sel     = WB_PC4;
                ctrl.op2_immediate = FMT_I;
                ctrl.is_jalr       = 1'b1;
                uses_rs1           = 1'b1;
            end
            OPC_LUI: begin
                ctrl.wdata_sel     = WB_IMM;
                ctrl.op2_immediate = FMT_U;
                ctrl.op1_zero      = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.wdata_sel     = WB_ALU;
                ctrl.op2_immediate = FMT_U;
                ctrl.op1_pc        = 1'b1;
            end
            OPC_MISC_MEM: begin
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm32 = '0;
        unique case (ctrl.op2_immediate)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage with handshake, load-use bubble, flush and halt.
// Optional DECODE_ILLEGAL_TRAP_EN adds illegal_instr and halts on it.
module decode_stage
    import decode_pkg::*;
#(
    parameter int         XLEN        = 32,
    parameter int         RA_W        = 5,
    parameter logic [6:0] DONE_OPCODE = 7'b1110011
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [RA_W-1:0] rd,
    output logic [RA_W-1:0] rs1,
    output logic [RA_W-1:0] rs2,
    output logic [XLEN-1:0] imm,
    output logic [3:0]      alu_func,
    output logic [2:0]      wdata_sel,
    output logic [2:0]      op2_immediate,
    output logic            op1_pc,
    output logic            op1_zero,
    output logic            load_control,
    output logic            store_control,
    output logic            is_branch,
    output logic            is_jal,
    output logic            is_jalr,
    output logic [2:0]      br_funct3,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic            illegal_instr,
`endif
    output logic            program_done
);

    ctrl_t           dec_ctrl, ctrl_new, ctrl_d, ctrl_q;
    logic [XLEN-1:0] dec_imm, imm_new, imm_d, imm_q, pc_d, pc_q;
    logic            dec_rs1, dec_rs2, dec_ill;
    logic            use_rs1, use_rs2, is_done, halt_now;
    logic [RA_W-1:0] rd_new, rs1_new, rs2_new;
    logic [RA_W-1:0] rd_d, rd_q, rs1_d, rs1_q, rs2_d, rs2_q;
    logic            valid_d, valid_q, done_d, done_q;
    logic [0:0]      state_d, state_q;
    logic            hazard, accept;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic            ill_d, ill_q;
`endif

    decode_ctrl #(.XLEN(XLEN)) u_ctrl (
        .instr    (instr),
        .ctrl     (dec_ctrl),
        .imm      (dec_imm),
        .uses_rs1 (dec_rs1),
        .uses_rs2 (dec_rs2),
        .illegal  (dec_ill)
    );

    assign is_done = instr[6:0] == DONE_OPCODE;

    // DONE carries an all-zero control word; other illegal words become NOP
    always_comb begin
        ctrl_new = dec_ctrl;
        imm_new  = dec_imm;
        use_rs1  = dec_rs1;
        use_rs2  = dec_rs2;
        if (is_done) begin
            ctrl_new = '0;
            imm_new  = '0;
            use_rs1  = 1'b0;
            use_rs2  = 1'b0;
        end else if (dec_ill) begin
            ctrl_new           = '0;
            ctrl_new.wdata_sel = WB_NONE;
            imm_new            = '0;
            use_rs1            = 1'b0;
            use_rs2            = 1'b0;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign halt_now = is_done || dec_ill;
`else
    assign halt_now = is_done;
`endif

    assign rs1_new = RA_W'(instr[19:15]);
    assign rs2_new = RA_W'(instr[24:20]);
    assign rd_new  = (ctrl_new.op2_immediate == FMT_S ||
                      ctrl_new.op2_immediate == FMT_B) ? '0 : RA_W'(instr[11:7]);

    assign hazard = valid_q && ctrl_q.load_control && rd_q != '0 &&
                    ((rd_q == rs1_new && use_rs1) ||
                     (rd_q == rs2_new && use_rs2));

    assign in_ready = n_reset && state_q == ST_RUN && !flush && !hazard &&
                      (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        state_d = state_q;
        done_d  = done_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
        ill_d   = ill_q;
`endif
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_new;
            imm_d   = imm_new;
            pc_d    = pc_in;
            rd_d    = rd_new;
            rs1_d   = rs1_new;
            rs2_d   = rs2_new;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ill_d   = dec_ill && !is_done;
`endif
            if (halt_now) begin
                state_d = ST_HALT;
                done_d  = 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            state_q <= ST_RUN;
            done_q  <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ill_q   <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            state_q <= state_d;
            done_q  <= done_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ill_q   <= ill_d;
`endif
        end
    end

    assign out_valid     = valid_q;
    assign pc_out        = pc_q;
    assign rd            = rd_q;
    assign rs1           = rs1_q;
    assign rs2           = rs2_q;
    assign imm           = imm_q;
    assign alu_func      = ctrl_q.alu_func;
    assign wdata_sel     = ctrl_q.wdata_sel;
    assign op2_immediate = ctrl_q.op2_immediate;
    assign op1_pc        = ctrl_q.op1_pc;
    assign op1_zero      = ctrl_q.op1_zero;
    assign load_control  = ctrl_q.load_control;
    assign store_control = ctrl_q.store_control;
    assign is_branch     = ctrl_q.is_branch;
    assign is_jal        = ctrl_q.is_jal;
    assign is_jalr       = ctrl_q.is_jalr;
    assign br_funct3     = ctrl_q.br_funct3;
    assign program_done  = done_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal_instr = valid_q && ill_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, load-use bubble,
// backpressure, flush and sticky halt.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        n_reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [3:0]  alu_func;
    logic [2:0]  wdata_sel, op2_immediate, br_funct3;
    logic        op1_pc, op1_zero, load_control, store_control;
    logic        is_branch, is_jal, is_jalr, program_done;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal_instr;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    decode_stage dut (
        .clock         (clock),
        .n_reset       (n_reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .pc_in         (pc_in),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .pc_out        (pc_out),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .imm           (imm),
        .alu_func      (alu_func),
        .wdata_sel     (wdata_sel),
        .op2_immediate (op2_immediate),
        .op1_pc        (op1_pc),
        .op1_zero      (op1_zero),
        .load_control  (load_control),
        .store_control (store_control),
        .is_branch     (is_branch),
        .is_jal        (is_jal),
        .is_jalr       (is_jalr),
        .br_funct3     (br_funct3),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .illegal_instr (illegal_instr),
`endif
        .program_done  (program_done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [31:0] w, input logic [31:0] pc);
        in_valid = 1'b1;
        instr    = w;
        pc_in    = pc;
    endtask

    initial begin
        n_reset   = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        pc_in     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_done", program_done, 0);
        check("rst_rd", rd, 0);
        check("rst_imm", imm, 0);
        n_reset = 1'b1;
        #1;
        check("run_in_ready", in_ready, 1);

        // ADD x3,x1,x2
        present(32'h002081B3, 32'h100);
        tick();
        in_valid = 1'b0;
        check("add_valid", out_valid, 1);
        check("add_rd", rd, 3);
        check("add_rs1", rs1, 1);
        check("add_rs2", rs2, 2);
        check("add_alu", alu_func, 0);
        check("add_wsel", wdata_sel, 0);
        check("add_op2", op2_immediate, 0);
        check("add_pc", pc_out, 32'h100);

        // LW x5,0(x1) then dependent ADD x6,x5,x1
        present(32'h0000A283, 32'h104);
        tick();
        present(32'h00128333, 32'h108);
        #1;
        check("lw_load", load_control, 1);
        check("lw_rd", rd, 5);
        check("lw_wsel", wdata_sel, 1);
        check("lw_op2", op2_immediate, 1);
        check("lu_in_ready", in_ready, 0);
        tick();
        check("lu_bubble", out_valid, 0);
        check("lu_ready_again", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("lu_add_valid", out_valid, 1);
        check("lu_add_rd", rd, 6);
        check("lu_add_rs1", rs1, 5);
        check("lu_add_pc", pc_out, 32'h108);

        // BEQ x1,x2,+8
        present(32'h00208463, 32'h10C);
        tick();
        in_valid = 1'b0;
        check("beq_branch", is_branch, 1);
        check("beq_f3", br_funct3, 0);
        check("beq_imm", imm, 8);
        check("beq_rd", rd, 0);
        check("beq_op2", op2_immediate, 3);

        // ADDI x1,x0,-1 then held under backpressure
        present(32'hFFF00093, 32'h200);
        tick();
        out_ready = 1'b0;
        present(32'h123452B7, 32'h204);
        #1;
        check("addi_imm", imm, 32'hFFFF_FFFF);
        check("addi_rd", rd, 1);
        check("addi_op2", op2_immediate, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_imm", imm, 32'hFFFF_FFFF);
            check("bp_pc", pc_out, 32'h200);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("lui_valid", out_valid, 1);
        check("lui_rd", rd, 5);
        check("lui_imm", imm, 32'h1234_5000);
        check("lui_wsel", wdata_sel, 3);
        check("lui_op1_zero", op1_zero, 1);
        check("lui_pc", pc_out, 32'h204);

        // flush with a held instruction and a new one offered
        out_ready = 1'b0;
        flush     = 1'b1;
        present(32'h002081B3, 32'h300);
        #1;
        check("fl_in_ready", in_ready, 0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("fl_valid", out_valid, 0);
        tick();
        check("fl_not_emitted", out_valid, 0);

        // unknown opcode decodes as NOP
        present(32'h0000007F, 32'h310);
        tick();
        in_valid = 1'b0;
        check("nop_valid", out_valid, 1);
        check("nop_wsel", wdata_sel, 4);
        check("nop_op2", op2_immediate, 0);
        check("nop_load", load_control, 0);
        tick();

        // DONE instruction halts and sticks
        present(32'h00000073, 32'h400);
        tick();
        present(32'h002081B3, 32'h404);
        #1;
        check("done_valid", out_valid, 1);
        check("done_flag", program_done, 1);
        check("done_wsel", wdata_sel, 0);
        check("done_in_ready", in_ready, 0);
        tick();
        check("halt_drained", out_valid, 0);
        check("halt_flag", program_done, 1);
        check("halt_in_ready", in_ready, 0);
        tick();
        check("halt_sticky", program_done, 1);
        check("halt_no_intake", out_valid, 0);
        n_reset = 1'b0;
        #1;
        check("rst2_done", program_done, 0);
        check("rst2_in_ready", in_ready, 0);
        in_valid = 1'b0;
        tick();
        n_reset = 1'b1;
        tick();
        check("rst2_run", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
